flip_engine: RTL and testbench

- Sequential move executor for the othello board, directly downstream of board_ram's direction detector (dir) and upstream of board_ram's write port and the redraw/plothelper stage.
- On a confirmed placement, writes the placed disk, then walks each flagged direction, re-validates the capture line and flips the captured opponent disks one per cycle.
- Emits a per-cell strobe so the drawing path repaints only changed cells, and reports the total flip count.

---
 rtl/flip_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_flip_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flip_engine.sv
// Othello move executor: places a disk, re-validates each flagged
// direction and flips captured disks one cell per cycle.
module flip_engine #(
    parameter logic [1:0] CELL_EMPTY = 2'b00,
    parameter logic [1:0] CELL_BLACK = 2'b01,
    parameter logic [1:0] CELL_WHITE = 2'b10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       side,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [7:0] dir,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [1:0] wr_data,
    output logic       cell_upd,
    output logic [2:0] upd_x,
    output logic [2:0] upd_y,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [4:0] flip_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_NEXT,
        S_SCAN,
        S_FLIP,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic       side_q;
    logic [2:0] x_q, y_q;
    logic [7:0] mask;
    logic [2:0] d;
    logic [3:0] k;
    logic [2:0] r;
    logic [4:0] acc;
    logic       ill_q;

    logic [1:0] own, opp;
    logic       found;
    logic [2:0] sel;
    logic       xp, xm, yp, ym;
    logic signed [4:0] bx, by, sk, cx, cy;
    logic       on_board;
    logic [5:0] cand;

    assign own = side_q ? CELL_WHITE : CELL_BLACK;
    assign opp = side_q ? CELL_BLACK : CELL_WHITE;

    // Lowest pending direction; processed bits are cleared from mask.
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= d)) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
    end

    always_comb begin
        xp = 1'b0;
        xm = 1'b0;
        yp = 1'b0;
        ym = 1'b0;
        unique case (d)
            3'd0: ym = 1'b1;
            3'd1: begin xp = 1'b1; ym = 1'b1; end
            3'd2: xp = 1'b1;
            3'd3: begin xp = 1'b1; yp = 1'b1; end
            3'd4: yp = 1'b1;
            3'd5: begin xm = 1'b1; yp = 1'b1; end
            3'd6: xm = 1'b1;
            3'd7: begin xm = 1'b1; ym = 1'b1; end
        endcase
    end

    // Signed candidate coordinates; bits [4:3] nonzero means off board.
    always_comb begin
        bx = $signed({2'b00, x_q});
        by = $signed({2'b00, y_q});
        sk = $signed({1'b0, k});
        cx = bx;
        cy = by;
        if (xp) cx = bx + sk;
        else if (xm) cx = bx - sk;
        if (yp) cy = by + sk;
        else if (ym) cy = by - sk;
    end

    assign on_board = (cx[4:3] == 2'b00) && (cy[4:3] == 2'b00);
    assign cand     = {cy[2:0], cx[2:0]};

    always_comb begin
        state_n  = state;
        rd_addr  = 6'd0;
        wr_en    = 1'b0;
        wr_addr  = 6'd0;
        wr_data  = CELL_EMPTY;
        cell_upd = 1'b0;
        upd_x    = 3'd0;
        upd_y    = 3'd0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_PLACE;
            end
            S_PLACE: begin
                rd_addr = {y_q, x_q};
                if (rd_data != CELL_EMPTY) begin
                    state_n = S_DONE;
                end else begin
                    wr_en    = 1'b1;
                    wr_addr  = {y_q, x_q};
                    wr_data  = own;
                    cell_upd = 1'b1;
                    upd_x    = x_q;
                    upd_y    = y_q;
                    state_n  = S_NEXT;
                end
            end
            S_NEXT: begin
                state_n = found ? S_SCAN : S_DONE;
            end
            S_SCAN: begin
                if (!on_board) begin
                    state_n = S_NEXT;
                end else begin
                    rd_addr = cand;
                    if (rd_data == opp) state_n = S_SCAN;
                    else if (rd_data == own && r != 3'd0) state_n = S_FLIP;
                    else state_n = S_NEXT;
                end
            end
            S_FLIP: begin
                wr_en    = 1'b1;
                wr_addr  = cand;
                wr_data  = own;
                cell_upd = 1'b1;
                upd_x    = cand[2:0];
                upd_y    = cand[5:3];
                if ({1'b0, r} == k) state_n = S_NEXT;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = ill_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            side_q     <= 1'b0;
            x_q        <= 3'd0;
            y_q        <= 3'd0;
            mask       <= 8'd0;
            d          <= 3'd0;
            k          <= 4'd0;
            r          <= 3'd0;
            acc        <= 5'd0;
            ill_q      <= 1'b0;
            flip_count <= 5'd0;
        end else begin
            state <= state_n;
            // Publish the count as DONE is entered so it is valid with done.
            if (state != S_DONE && state_n == S_DONE) flip_count <= acc;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        side_q <= side;
                        x_q    <= x;
                        y_q    <= y;
                        mask   <= dir;
                        acc    <= 5'd0;
                        ill_q  <= 1'b0;
                        d      <= 3'd0;
                    end
                end
                S_PLACE: begin
                    ill_q <= (rd_data != CELL_EMPTY);
                    d     <= 3'd0;
                end
                S_NEXT: begin
                    if (found) begin
                        d         <= sel;
                        mask[sel] <= 1'b0;
                        k         <= 4'd1;
                        r         <= 3'd0;
                    end
                end
                S_SCAN: begin
                    if (on_board && rd_data == opp) begin
                        r <= r + 3'd1;
                        k <= k + 4'd1;
                    end else begin
                        k <= 4'd1;
                    end
                end
                S_FLIP: begin
                    acc <= acc + 5'd1;
                    k   <= k + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flip_engine.sv
// Bench for flip_engine: board memory, line-walking reference model
// and a per-cycle write/done comparator.
module tb_flip_engine;

    logic       clock;
    logic       resetn;
    logic       start;
    logic       side;
    logic [2:0] x, y;
    logic [7:0] dir;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       cell_upd;
    logic [2:0] upd_x, upd_y;
    logic       busy, done, illegal;
    logic [4:0] flip_count;

    int checks = 0;
    int failures = 0;
    int upd_total = 0;

    logic [1:0] brd [64];
    logic [7:0] exp_q [$];
    int         exp_cnt;
    logic       exp_ill;

    flip_engine dut (
        .clock(clock), .resetn(resetn), .start(start), .side(side),
        .x(x), .y(y), .dir(dir), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cell_upd(cell_upd), .upd_x(upd_x), .upd_y(upd_y),
        .busy(busy), .done(done), .illegal(illegal),
        .flip_count(flip_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rd_data = brd[rd_addr];

    always @(posedge clock) begin
        if (wr_en) brd[wr_addr] <= wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] peek(input int px, input int py);
        if (px < 0 || px > 7 || py < 0 || py > 7) return 2'b11;
        return brd[py * 8 + px];
    endfunction

    // Reference: walk each flagged line on the current board snapshot.
    task automatic model(input logic s, input int tx, input int ty,
                         input logic [7:0] dm);
        int dxs [8];
        int dys [8];
        logic [1:0] own, opp;
        int n;
        dxs = '{0, 1, 1, 1, 0, -1, -1, -1};
        dys = '{-1, -1, 0, 1, 1, 1, 0, -1};
        own = s ? 2'b10 : 2'b01;
        opp = s ? 2'b01 : 2'b10;
        exp_q.delete();
        exp_cnt = 0;
        exp_ill = 1'b0;
        if (peek(tx, ty) != 2'b00) begin
            exp_ill = 1'b1;
            return;
        end
        exp_q.push_back({6'(ty * 8 + tx), own});
        for (int dd = 0; dd < 8; dd++) begin
            if (dm[dd]) begin
                n = 1;
                while (peek(tx + n * dxs[dd], ty + n * dys[dd]) == opp) n++;
                if (peek(tx + n * dxs[dd], ty + n * dys[dd]) == own && n > 1) begin
                    for (int m = 1; m < n; m++)
                        exp_q.push_back({6'((ty + m * dys[dd]) * 8 + tx + m * dxs[dd]), own});
                    exp_cnt += n - 1;
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (cell_upd) upd_total++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             {wr_addr, wr_data});
                end else begin
                    chk("wr_cell", {wr_addr, wr_data}, exp_q.pop_front());
                    chk("upd_xy", {upd_y, upd_x}, wr_addr);
                    chk("upd_pulse", cell_upd, 1);
                    chk("busy_wr", busy, 1);
                end
            end else begin
                chk("upd_quiet", cell_upd, 0);
            end
            if (done) begin
                chk("illegal", illegal, exp_ill);
                chk("flip_count", flip_count, exp_cnt);
                chk("writes_left", exp_q.size(), 0);
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 64; i++) brd[i] = 2'b00;
    endtask

    task automatic put(input int px, input int py, input logic [1:0] v);
        brd[py * 8 + px] = v;
    endtask

    task automatic run_move(input logic s, input int tx, input int ty,
                            input logic [7:0] dm, input bit poke,
                            output int lat);
        model(s, tx, ty, dm);
        @(negedge clock);
        side = s;
        x = 3'(tx);
        y = 3'(ty);
        dir = dm;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dir = 8'h00;
        side = ~s;
        x = 3'd0;
        y = 3'd0;
        for (lat = 1; lat < 400; lat++) begin
            if (done) break;
            start = poke && (lat == 3);
            @(negedge clock);
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=<400", lat);
        end
        @(negedge clock);
        chk("idle_after", busy, 0);
    endtask

    int lat;
    int u0;
    int seen;

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        side = 1'b0;
        x = 3'd0;
        y = 3'd0;
        dir = 8'h00;
        clear_board();
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done, illegal, cell_upd}, 0);
        chk("rst_flip_count", flip_count, 0);
        chk("rst_addrs", {rd_addr, wr_addr, wr_data, upd_x, upd_y}, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Single capture east along row 3, cycle-exact.
        put(3, 3, 2'b10);
        put(4, 3, 2'b01);
        model(1'b0, 2, 3, 8'h04);
        @(negedge clock);
        side = 1'b0; x = 3'd2; y = 3'd3; dir = 8'h04; start = 1'b1;
        @(negedge clock);
        start = 1'b0; dir = 8'h00;
        chk("t1_place", {wr_en, wr_addr, wr_data}, {1'b1, 6'd26, 2'b01});
        @(negedge clock);
        chk("t1_next_nowr", wr_en, 0);
        @(negedge clock);
        chk("t1_scan1", rd_addr, 27);
        @(negedge clock);
        chk("t1_scan2", rd_addr, 28);
        @(negedge clock);
        chk("t1_flip", {wr_en, wr_addr, wr_data}, {1'b1, 6'd27, 2'b01});
        @(negedge clock);
        chk("t1_busy", {busy, done}, 2'b10);
        @(negedge clock);
        chk("t1_done", {done, illegal, flip_count}, {2'b10, 5'd1});
        @(negedge clock);
        chk("t1_idle", busy, 0);
        chk("t1_board", brd[27], 2'b01);

        // Occupied target.
        clear_board();
        put(3, 3, 2'b10);
        run_move(1'b0, 3, 3, 8'hFF, 1'b0, lat);
        chk("ill_latency", lat, 2);

        // Corner, both directions off board immediately.
        clear_board();
        run_move(1'b0, 0, 0, 8'h81, 1'b0, lat);
        chk("corner_latency", lat, 7);

        // East 2 then south 3.
        clear_board();
        put(3, 2, 2'b10); put(4, 2, 2'b10); put(5, 2, 2'b01);
        put(2, 3, 2'b10); put(2, 4, 2'b10); put(2, 5, 2'b10);
        put(2, 6, 2'b01);
        u0 = upd_total;
        run_move(1'b0, 2, 2, 8'h14, 1'b0, lat);
        chk("es_upd_pulses", upd_total - u0, 6);
        chk("es_count_lit", flip_count, 5);
        repeat (3) @(negedge clock);
        chk("es_count_held", flip_count, 5);

        // Line ends in empty cell; start poked while busy.
        clear_board();
        put(4, 5, 2'b01); put(3, 5, 2'b01);
        run_move(1'b1, 5, 5, 8'h40, 1'b1, lat);
        chk("empty_end_count", flip_count, 0);
        chk("empty_end_board", brd[5 * 8 + 4], 2'b01);

        // All directions flagged, mixed outcomes.
        clear_board();
        put(4, 3, 2'b10); put(4, 2, 2'b01);
        put(5, 3, 2'b10); put(6, 2, 2'b10); put(7, 1, 2'b01);
        put(5, 4, 2'b01);
        put(3, 4, 2'b10); put(2, 4, 2'b10); put(1, 4, 2'b10); put(0, 4, 2'b10);
        put(5, 5, 2'b10);
        put(3, 3, 2'b01);
        run_move(1'b0, 4, 4, 8'hFF, 1'b1, lat);
        chk("all_dirs_count", flip_count, 3);
        chk("all_dirs_w_kept", brd[4 * 8 + 2], 2'b10);

        // Reset in the middle of a six-disk flip run.
        clear_board();
        for (int i = 1; i < 7; i++) put(i, 0, 2'b10);
        put(0, 0, 2'b01);
        model(1'b0, 7, 0, 8'h40);
        @(negedge clock);
        side = 1'b0; x = 3'd7; y = 3'd0; dir = 8'h40; start = 1'b1;
        @(negedge clock);
        start = 1'b0; dir = 8'h00;
        seen = 0;
        for (int c = 0; c < 60 && seen < 3; c++) begin
            if (cell_upd) seen++;
            if (seen < 3) @(negedge clock);
        end
        chk("rst_mid_flip", {wr_en, wr_addr}, {1'b1, 6'd5});
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_outs", {wr_en, cell_upd, busy, done, illegal}, 0);
        chk("arst_count", flip_count, 0);
        chk("arst_addr", {rd_addr, wr_addr, wr_data}, 0);
        chk("arst_kept", {brd[7], brd[6], brd[5]}, {2'b01, 2'b01, 2'b10});
        repeat (2) @(negedge clock);
        exp_q.delete();
        resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || wr_en) seen++;
        end
        chk("arst_no_done", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
